// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory line responder.
// State encoding, line geometry and countdown width.
package dmem_pkg;

  localparam int LINE_BITS   = 256;
  localparam int OFFSET_BITS = 5;
  localparam int CNT_BITS    = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK,
    TURN
  } state_e;

endpackage

// File: rtl/dmem_line_array.sv
// Line storage: synchronous write port and registered read port.
// Contents are not reset; only the read register clears on reset.
module dmem_line_array
  import dmem_pkg::*;
#(
  parameter int ADDR_BITS = 9
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 i_we,
  input  logic                 i_re,
  input  logic [ADDR_BITS-1:0] i_idx,
  input  logic [LINE_BITS-1:0] i_wdata,
  output logic [LINE_BITS-1:0] o_rdata
);

  logic [LINE_BITS-1:0] r_mem [2**ADDR_BITS];
  logic [LINE_BITS-1:0] r_rdata;

  always_ff @(posedge clk_i) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_line_responder.sv
// Memory-side responder for 256-bit line reads/writes with fixed latency.
// Request is latched at accept; one-cycle ack, then a turnaround cycle.
module dmem_line_responder
  import dmem_pkg::*;
#(
  parameter int LATENCY        = 10,
  parameter int LINE_ADDR_BITS = 9
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 write_i,
  input  logic [31:0]          addr_i,
  input  logic [LINE_BITS-1:0] data_i,
  output logic                 ack_o,
  output logic [LINE_BITS-1:0] data_o
);

  localparam int IDX_HI = LINE_ADDR_BITS + OFFSET_BITS - 1;
  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(LATENCY - 1);

  state_e                    r_state;
  state_e                    w_next;
  logic [CNT_BITS-1:0]       r_cnt;
  logic [LINE_ADDR_BITS-1:0] r_idx;
  logic                      r_write;
  logic [LINE_BITS-1:0]      r_wdata;

  logic                      w_accept;
  logic                      w_commit;
  logic                      w_dec;
  logic [LINE_ADDR_BITS-1:0] w_idx;
  logic                      w_unused;

  assign w_idx    = addr_i[IDX_HI:OFFSET_BITS];
  assign w_unused = ^{addr_i[31:IDX_HI+1], addr_i[OFFSET_BITS-1:0]};

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_commit = 1'b0;
    w_dec    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (enable_i) begin
          w_accept = 1'b1;
          w_next   = WAIT;
        end
      end
      WAIT: begin
        // Initiator withdrawing the request cancels it without touching memory
        if (!enable_i) begin
          w_next = IDLE;
        end else if (r_cnt == '0) begin
          w_commit = 1'b1;
          w_next   = ACK;
        end else begin
          w_dec = 1'b1;
        end
      end
      ACK:     w_next = TURN;
      TURN:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt   <= CNT_LOAD;
        r_idx   <= w_idx;
        r_write <= write_i;
        r_wdata <= data_i;
      end else if (w_dec) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  dmem_line_array #(
    .ADDR_BITS(LINE_ADDR_BITS)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_we    (w_commit & r_write),
    .i_re    (w_commit & ~r_write),
    .i_idx   (r_idx),
    .i_wdata (r_wdata),
    .o_rdata (data_o)
  );

  assign ack_o = (r_state == ACK);

endmodule

// File: tb/tb_dmem_line_responder.sv
// Randomized bench for dmem_line_responder with a cycle-count memory model.
// Directed scenarios pin latency, aliasing, abort and reset behaviour.
module tb_dmem_line_responder;

  localparam int LAT = 10;
  localparam int NL  = 512;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b0;
  logic         wr  = 1'b0;
  logic [31:0]  addr = '0;
  logic [255:0] wdat = '0;
  logic         ack;
  logic [255:0] rdat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_line_responder #(
    .LATENCY(LAT),
    .LINE_ADDR_BITS(9)
  ) u_dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .enable_i (en),
    .write_i  (wr),
    .addr_i   (addr),
    .data_i   (wdat),
    .ack_o    (ack),
    .data_o   (rdat)
  );

  // Model: a request accepted at edge A completes at edge A+LAT unless
  // enable drops first; the next accept is possible 3 edges after completion.
  logic [255:0] m_mem [NL];
  logic [255:0] pre   [NL];
  int           cyc;
  bit           m_busy;
  int           m_acc;
  bit           m_wr;
  int           m_idx;
  logic [255:0] m_data;
  int           m_ready;
  bit           exp_ack;
  bit           exp_rd;
  logic [255:0] exp_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  = 0;
      exp_ack = 0;
      exp_rd  = 0;
      m_ready = 0;
      cyc     = 0;
    end else begin
      cyc++;
      exp_ack = 0;
      exp_rd  = 0;
      if (m_busy) begin
        if (!en) begin
          m_busy  = 0;
          m_ready = cyc + 1;
        end else if (cyc == m_acc + LAT) begin
          exp_ack = 1;
          m_busy  = 0;
          m_ready = cyc + 3;
          if (m_wr) begin
            m_mem[m_idx] = m_data;
          end else begin
            exp_rd   = 1;
            exp_data = m_mem[m_idx];
          end
        end
      end else if (en && cyc >= m_ready) begin
        m_busy = 1;
        m_acc  = cyc;
        m_wr   = wr;
        m_idx  = int'((addr >> 5) % NL);
        m_data = wdat;
      end
    end
  end

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("ack_cycle", 256'(ack), 256'(exp_ack));
      if (exp_ack && exp_rd) begin
        chk("read_data", rdat, exp_data);
      end
    end
  end

  // Drive a request at the current negedge; return edges from accept to ack.
  task automatic xact(input bit w, input logic [31:0] a,
                      input logic [255:0] d, output int n);
    bit ok;
    en   = 1'b1;
    wr   = w;
    addr = a;
    wdat = d;
    @(posedge clk);
    n  = 0;
    ok = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (ack) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got no ack want ack within 40 edges");
    end
  endtask

  task automatic gap(input int k);
    en = 1'b0;
    repeat (k) @(negedge clk);
  endtask

  logic [255:0] pat_a5;
  logic [255:0] pat_w;
  logic [255:0] pat_x;
  logic [255:0] pat_y;
  logic [255:0] pat_z;
  int           n;
  int           acks;

  initial begin
    pat_a5 = {32{8'hA5}};
    pat_w  = {4{64'h0123456789ABCDEF}};
    pat_x  = {8{32'h0BADF00D}};
    pat_y  = {8{32'hC0FFEE11}};
    pat_z  = {8{32'h13579BDF}};
    for (int i = 0; i < NL; i++) begin
      pre[i] = {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    end
    pre[3] = pat_a5;
    pre[5] = {8{32'hDEADBEEF}};
    pre[7] = {8{32'h77665544}};

    repeat (3) @(negedge clk);
    chk("reset_ack", 256'(ack), 256'd0);
    chk("reset_data", rdat, 256'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NL; i++) begin
      xact(1'b1, 32'(i) << 5, pre[i], n);
      gap(2);
    end

    // Read line 3 through a byte address
    xact(1'b0, 32'h60, '0, n);
    chk("t1_latency", 256'(n), 256'd10);
    chk("t1_data", rdat, pat_a5);
    @(posedge clk);
    #1 chk("t1_ack_one_cycle", 256'(ack), 256'd0);
    @(negedge clk);
    gap(1);

    xact(1'b1, 32'h1E0, pat_w, n);
    gap(2);
    xact(1'b0, 32'h1E0, '0, n);
    chk("t2_data", rdat, pat_w);
    gap(2);
    xact(1'b0, 32'h1C0, '0, n);
    chk("t2_line14", rdat, pre[14]);
    gap(2);
    xact(1'b0, 32'h200, '0, n);
    chk("t2_line16", rdat, pre[16]);
    gap(2);

    // Enable held high across two requests
    xact(1'b1, 32'h40, pat_x, n);
    wr   = 1'b0;
    addr = 32'h80;
    n    = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (ack) break;
    end
    chk("t3_spacing", 256'(n), 256'(LAT + 3));
    chk("t3_read4", rdat, pre[4]);
    gap(2);
    xact(1'b0, 32'h40, '0, n);
    chk("t3_line2", rdat, pat_x);
    gap(2);

    // Abort a write to line 5 at wait cycle 4
    en   = 1'b1;
    wr   = 1'b1;
    addr = 32'hA0;
    wdat = pat_y;
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    en   = 1'b0;
    acks = 0;
    repeat (20) begin
      @(negedge clk);
      if (ack) acks++;
    end
    chk("t4_no_ack", 256'(acks), 256'd0);
    xact(1'b0, 32'hA0, '0, n);
    chk("t4_line5", rdat, {8{32'hDEADBEEF}});
    gap(2);

    // Reset in the middle of a write to line 7
    en   = 1'b1;
    wr   = 1'b1;
    addr = 32'hE0;
    wdat = pat_z;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_ack", 256'(ack), 256'd0);
    chk("t5_rst_data", rdat, 256'd0);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    xact(1'b0, 32'hE0, '0, n);
    chk("t5_latency", 256'(n), 256'd10);
    chk("t5_line7", rdat, {8{32'h77665544}});
    gap(2);

    // Upper address bits alias onto line 1
    xact(1'b1, 32'h4000_0020, pat_z, n);
    gap(2);
    xact(1'b0, 32'h20, '0, n);
    chk("t6_alias", rdat, pat_z);
    gap(2);

    for (int it = 0; it < 300; it++) begin
      logic [31:0] ra;
      logic [255:0] rd;
      bit rw;
      ra = ($urandom & 32'hFFFF_C000) | ($urandom % 32);
      if ($urandom % 2 == 0) begin
        ra = ra | (32'($urandom % 8) << 5);
      end else begin
        ra = ra | (32'($urandom % NL) << 5);
      end
      rd = {$urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom};
      rw = 1'($urandom % 2);
      if ($urandom % 8 == 0) begin
        en   = 1'b1;
        wr   = rw;
        addr = ra;
        wdat = rd;
        @(posedge clk);
        repeat ($urandom_range(0, LAT - 2)) @(posedge clk);
        @(negedge clk);
        gap(2);
      end else begin
        xact(rw, ra, rd, n);
        gap(2 + $urandom % 3);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
